// File: rtl/cpu_controller.sv
// Multi-cycle control FSM for the simple RISC datapath: sequences register reads, A/B/C/status loads and write-back.
// Optional build macro CPU_CTRL_ILLEGAL_HALT_EN: an illegal instruction parks the FSM in HALT until reset.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// WAIT     | idle, waiting=1, accepts start and latches opcode/op
// DECODE   | classify latched opcode/op, pick the instruction path
// GET_A    | read Rn into datapath A
// GET_B    | read Rm into datapath B
// ALU      | run the ALU, load C (or status for CMP)
// WR_REG   | write C back to Rd
// WR_IMM   | write sximm8 back to Rn
// HALT     | (macro only) illegal instruction seen, exited only by reset
module cpu_controller (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic [2:0] i_opcode,
    input  logic [1:0] i_op,
    output logic       o_waiting,
    output logic [1:0] o_reg_sel,
    output logic       o_load_a,
    output logic       o_load_b,
    output logic       o_load_c,
    output logic       o_load_s,
    output logic       o_asel,
    output logic       o_bsel,
    output logic [1:0] o_wb_sel,
    output logic       o_w_en,
    output logic [1:0] o_alu_op,
    output logic       o_illegal
);

    typedef enum logic [2:0] {
        S_WAIT,
        S_DECODE,
        S_GET_A,
        S_GET_B,
        S_ALU,
        S_WR_REG,
        S_WR_IMM
`ifdef CPU_CTRL_ILLEGAL_HALT_EN
        , S_HALT
`endif
    } state_t;

    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    localparam logic [1:0] SEL_RM = 2'b00;
    localparam logic [1:0] SEL_RD = 2'b01;
    localparam logic [1:0] SEL_RN = 2'b10;

    state_t     r_state;
    state_t     w_next;
    logic [2:0] r_opcode;
    logic [1:0] r_op;
    logic       r_ill_pulse;

    logic w_mov_imm;
    logic w_mov_reg;
    logic w_alu;
    logic w_cmp;
    logic w_mvn;
    logic w_legal;
    logic w_need_a;

    assign w_mov_imm = (r_opcode == OPC_MOV) && (r_op == 2'b10);
    assign w_mov_reg = (r_opcode == OPC_MOV) && (r_op == 2'b00);
    assign w_alu     = (r_opcode == OPC_ALU);
    assign w_cmp     = w_alu && (r_op == 2'b01);
    assign w_mvn     = w_alu && (r_op == 2'b11);
    assign w_legal   = w_mov_imm || w_mov_reg || w_alu;
    assign w_need_a  = w_alu && !w_mvn;

    // Fields are captured only on the accepting edge so later decoder changes cannot disturb a running instruction.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= S_WAIT;
            r_opcode    <= 3'b000;
            r_op        <= 2'b00;
            r_ill_pulse <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_ill_pulse <= (r_state == S_DECODE) && !w_legal;
            if ((r_state == S_WAIT) && i_start) begin
                r_opcode <= i_opcode;
                r_op     <= i_op;
            end
        end
    end

    always_comb begin
        w_next    = r_state;
        o_waiting = 1'b0;
        o_reg_sel = SEL_RM;
        o_load_a  = 1'b0;
        o_load_b  = 1'b0;
        o_load_c  = 1'b0;
        o_load_s  = 1'b0;
        o_asel    = 1'b0;
        o_bsel    = 1'b0;
        o_wb_sel  = 2'b00;
        o_w_en    = 1'b0;
        o_alu_op  = 2'b00;
        o_illegal = 1'b0;

        case (r_state)
            S_WAIT: begin
                o_waiting = 1'b1;
                o_illegal = r_ill_pulse;
                if (i_start) begin
                    w_next = S_DECODE;
                end
            end
            S_DECODE: begin
                if (w_mov_imm) begin
                    w_next = S_WR_IMM;
                end else if (w_need_a) begin
                    w_next = S_GET_A;
                end else if (w_legal) begin
                    w_next = S_GET_B;
                end else begin
`ifdef CPU_CTRL_ILLEGAL_HALT_EN
                    w_next = S_HALT;
`else
                    w_next = S_WAIT;
`endif
                end
            end
            S_GET_A: begin
                o_reg_sel = SEL_RN;
                o_load_a  = 1'b1;
                w_next    = S_GET_B;
            end
            S_GET_B: begin
                o_reg_sel = SEL_RM;
                o_load_b  = 1'b1;
                w_next    = S_ALU;
            end
            S_ALU: begin
                // MOV reg is a pass-through: zero + B with an ADD.
                o_alu_op = w_mov_reg ? 2'b00 : r_op;
                o_asel   = w_mov_reg || w_mvn;
                o_load_s = w_cmp;
                o_load_c = !w_cmp;
                w_next   = w_cmp ? S_WAIT : S_WR_REG;
            end
            S_WR_REG: begin
                o_reg_sel = SEL_RD;
                o_wb_sel  = 2'b00;
                o_w_en    = 1'b1;
                w_next    = S_WAIT;
            end
            S_WR_IMM: begin
                o_reg_sel = SEL_RN;
                o_wb_sel  = 2'b10;
                o_w_en    = 1'b1;
                w_next    = S_WAIT;
            end
`ifdef CPU_CTRL_ILLEGAL_HALT_EN
            S_HALT: begin
                o_illegal = 1'b1;
                w_next    = S_HALT;
            end
`endif
            default: begin
                w_next = S_WAIT;
            end
        endcase
    end

endmodule

// File: tb/tb_cpu_controller.sv
// Randomized scoreboard bench for cpu_controller: an instruction-level model queues the expected busy-cycle outputs,
// a negedge monitor pops and compares them whenever the controller is busy or flags illegal.
module tb_cpu_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [2:0] opcode;
    logic [1:0] op;
    logic       waiting;
    logic [1:0] reg_sel;
    logic       load_a;
    logic       load_b;
    logic       load_c;
    logic       load_s;
    logic       asel;
    logic       bsel;
    logic [1:0] wb_sel;
    logic       w_en;
    logic [1:0] alu_op;
    logic       illegal;

    always #5 clk = ~clk;

    cpu_controller dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_start   (start),
        .i_opcode  (opcode),
        .i_op      (op),
        .o_waiting (waiting),
        .o_reg_sel (reg_sel),
        .o_load_a  (load_a),
        .o_load_b  (load_b),
        .o_load_c  (load_c),
        .o_load_s  (load_s),
        .o_asel    (asel),
        .o_bsel    (bsel),
        .o_wb_sel  (wb_sel),
        .o_w_en    (w_en),
        .o_alu_op  (alu_op),
        .o_illegal (illegal)
    );

    // {waiting, reg_sel, load_a, load_b, load_c, load_s, asel, bsel, wb_sel, w_en, alu_op, illegal}
    wire [14:0] dut_vec = {waiting, reg_sel, load_a, load_b, load_c, load_s, asel, bsel,
                           wb_sel, w_en, alu_op, illegal};
    localparam logic [14:0] IDLE = 15'h4000;

    logic [14:0] exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    bit          mon_en = 1'b0;

    function automatic logic [14:0] mk(input logic wt, input logic [1:0] rs, input logic la, input logic lb,
                                       input logic lc, input logic ls, input logic as, input logic [1:0] wb,
                                       input logic we, input logic [1:0] aop, input logic il);
        return {wt, rs, la, lb, lc, ls, as, 1'b0, wb, we, aop, il};
    endfunction

    task automatic chk(input string name, input logic [14:0] act, input logic [14:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Expected busy-cycle trace of one instruction, built from the instruction's meaning.
    task automatic model(input logic [2:0] opc, input logic [1:0] fop);
        bit mov_imm = (opc == 3'b110) && (fop == 2'b10);
        bit mov_reg = (opc == 3'b110) && (fop == 2'b00);
        bit alu     = (opc == 3'b101);
        bit is_cmp  = alu && (fop == 2'b01);
        bit is_mvn  = alu && (fop == 2'b11);
        exp_q.push_back(15'h0000);
        if (mov_imm) begin
            exp_q.push_back(mk(0, 2'b10, 0, 0, 0, 0, 0, 2'b10, 1, 2'b00, 0));
        end else if (mov_reg || alu) begin
            if (alu && !is_mvn)
                exp_q.push_back(mk(0, 2'b10, 1, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0));
            exp_q.push_back(mk(0, 2'b00, 0, 1, 0, 0, 0, 2'b00, 0, 2'b00, 0));
            exp_q.push_back(mk(0, 2'b00, 0, 0, !is_cmp, is_cmp, mov_reg || is_mvn, 2'b00, 0,
                               mov_reg ? 2'b00 : fop, 0));
            if (!is_cmp)
                exp_q.push_back(mk(0, 2'b01, 0, 0, 0, 0, 0, 2'b00, 1, 2'b00, 0));
        end else begin
            exp_q.push_back(mk(1, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 1));
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (waiting && !illegal)
                chk("idle", dut_vec, IDLE);
            else if (exp_q.size() == 0)
                chk("unexpected_busy", dut_vec, IDLE);
            else
                chk("step", dut_vec, exp_q.pop_front());
        end
    end

    // Called at a negedge with the controller in WAIT; returns at the negedge of the next WAIT cycle.
    task automatic run_instr(input logic [2:0] opc, input logic [1:0] fop, input bit hold);
        bit done = 1'b0;
        start  = 1'b1;
        opcode = opc;
        op     = fop;
        model(opc, fop);
        for (int c = 0; c < 12 && !done; c++) begin
            @(negedge clk);
            if (waiting) begin
                done = 1'b1;
            end else begin
                opcode = 3'($urandom);
                op     = 2'($urandom);
                start  = hold ? 1'b1 : 1'($urandom);
            end
        end
        if (!done) begin
            n_vec++;
            n_err++;
            $display("FAIL timeout waiting for WAIT after opcode=%b op=%b", opc, fop);
        end
        if (!hold) begin
            start = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    logic [2:0] leg_opc[6] = '{3'b110, 3'b110, 3'b101, 3'b101, 3'b101, 3'b101};
    logic [1:0] leg_op [6] = '{2'b10, 2'b00, 2'b00, 2'b01, 2'b10, 2'b11};

    initial begin
        logic [2:0] r_opc;
        logic [1:0] r_op;
        int         k;
        rst_n  = 1'b0;
        start  = 1'b0;
        opcode = 3'b000;
        op     = 2'b00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("reset_idle", dut_vec, IDLE);
        end

        mon_en = 1'b1;
        for (int i = 0; i < 6; i++) run_instr(leg_opc[i], leg_op[i], 1'b0);
`ifndef CPU_CTRL_ILLEGAL_HALT_EN
        run_instr(3'b000, 2'b00, 1'b0);
        run_instr(3'b101, 2'b00, 1'b1);
        run_instr(3'b111, 2'b01, 1'b1);
`endif
        run_instr(3'b101, 2'b00, 1'b1);
        run_instr(3'b101, 2'b11, 1'b1);
        run_instr(3'b110, 2'b10, 1'b0);

        for (int i = 0; i < 300; i++) begin
            k = $urandom_range(0, 5);
            r_opc = leg_opc[k];
            r_op  = leg_op[k];
`ifndef CPU_CTRL_ILLEGAL_HALT_EN
            if ($urandom_range(0, 4) == 0) begin
                r_opc = 3'($urandom);
                r_op  = 2'($urandom);
            end
`endif
            run_instr(r_opc, r_op, $urandom_range(0, 3) == 0);
        end
        start = 1'b0;
        repeat (3) @(negedge clk);
        mon_en = 1'b0;
        chk("queue_drained", 15'(exp_q.size()), 15'h0000);

        // Reset landing in GET_B of an ADD.
        start  = 1'b1;
        opcode = 3'b101;
        op     = 2'b00;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("getb_before_rst", dut_vec, mk(0, 2'b00, 0, 1, 0, 0, 0, 2'b00, 0, 2'b00, 0));
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_add", dut_vec, IDLE);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("after_rst_idle", dut_vec, IDLE);
        end

`ifdef CPU_CTRL_ILLEGAL_HALT_EN
        start  = 1'b1;
        opcode = 3'b000;
        op     = 2'b00;
        @(negedge clk);
        chk("halt_decode", dut_vec, 15'h0000);
        repeat (5) begin
            @(negedge clk);
            chk("halt", dut_vec, mk(0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 1));
        end
        start = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("halt_reset", dut_vec, IDLE);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
